branch_recovery_ctrl: RTL and testbench
=======================================

// Module: branch_recovery_ctrl
// PURPOSE
//  Consumes branch resolutions that the control buffer commits at the ROB head.
//  Updates the branch predictor for every committed control-flow op.
//  On a mispredict, sequences recovery: global flush pulse, frontend redirect handshake,
//  then a fixed backend stall while the RAT/free list restore from committed state.
//  Sits directly downstream of branch_top's control buffer, between the ROB and the frontend.
// PARAMETERS
//  XLEN            32  PC/target width
//  RECOVER_CYCLES  2   backend stall cycles after redirect accept (0 = none)
//  CNT_WIDTH       32  width of performance counters
// PORTS
//  clk             in   1          clock
//  rst             in   1          reset, asynchronous, active-high
//  cb_valid        in   1          committed control-flow op presented by the control buffer/ROB
//  cb_ready        out  1          block accepts the commit this cycle
//  cb_pc           in   XLEN       PC of the op
//  cb_taken        in   1          resolved direction
//  cb_target       in   XLEN       resolved taken target
//  cb_mispred      in   1          prediction differed from resolution
//  flush           out  1          one-cycle global backend/frontend flush
//  redirect_valid  out  1          redirect request to fetch
//  redirect_pc     out  XLEN       correct next PC
//  redirect_ready  in   1          fetch accepts the redirect
//  backend_stall   out  1          blocks dispatch during recovery
//  bp_upd_valid    out  1          predictor update strobe
//  bp_upd_pc       out  XLEN       updated branch PC
//  bp_upd_taken    out  1          resolved direction
//  bp_upd_target   out  XLEN       resolved target
//  br_count        out  CNT_WIDTH  committed control ops
//  mispred_count   out  CNT_WIDTH  committed mispredicts
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except cb_ready=1; captured PC regs and counters 0.
//  Accept: a commit is accepted when cb_valid && cb_ready. cb_ready=1 only in IDLE.
//  FSM (registered state; outputs are decoded from the state):
//   IDLE:     on accept with cb_mispred=1 -> FLUSH.
//             redirect_pc captured as cb_target if cb_taken, else cb_pc+4 (mod 2^XLEN).
//             On accept with cb_mispred=0 -> stay in IDLE.
//   FLUSH:    flush=1 for exactly this one cycle -> REDIRECT unconditionally.
//   REDIRECT: redirect_valid=1; redirect_pc held stable until redirect_ready.
//             On redirect_valid && redirect_ready -> RECOVER, load counter with RECOVER_CYCLES-1.
//             If RECOVER_CYCLES==0 -> IDLE instead.
//   RECOVER:  count down each cycle; when counter==0 -> IDLE.
//  backend_stall=1 in FLUSH, REDIRECT and RECOVER; 0 in IDLE.
//  Latency: a mispredict accepted in cycle T gives flush in T+1 and redirect_valid from T+2.
//   With redirect_ready held high, stall spans T+1..T+2+RECOVER_CYCLES and cb_ready
//   returns in T+3+RECOVER_CYCLES.
//  Predictor update: bp_upd_* are registered from the accept cycle.
//   bp_upd_valid is a 1-cycle pulse in T+1 for every accept, mispredicted or not.
//  Counters: br_count increments on every accept; mispred_count increments on accepts
//   with cb_mispred=1. Both wrap modulo 2^CNT_WIDTH and are not cleared by flush.
//  cb_valid outside IDLE is ignored (cb_ready=0); upstream holds it.
//  No second mispredict can start before IDLE is reached.
//  redirect_ready outside REDIRECT has no effect.
//  rst asserted in any state aborts recovery immediately (async): state IDLE, all outputs
//   at reset values; no residual flush, redirect or stall after rst deasserts.
// TESTING
//  Correct not-taken branch, pc=0x1000: bp_upd_valid pulse in T+1 with pc 0x1000, taken=0;
//   br_count=1, mispred_count=0; no flush, cb_ready stays 1.
//  Mispredict taken, target=0x2000, redirect_ready=1, RECOVER_CYCLES=2: flush in T+1 only;
//   redirect_valid in T+2 with redirect_pc 0x2000; stall T+1..T+4; cb_ready=1 in T+5.
//  Mispredict not-taken, pc=0xFFFFFFFC: redirect_pc=0x00000000 (wrap).
//   redirect_ready held 0 for 5 cycles: redirect_valid and redirect_pc stay stable, stall held.
//  Back-to-back cb_valid during recovery: second op not accepted until IDLE.
//   Then accepted with correct counts; RECOVER_CYCLES=0 variant goes REDIRECT->IDLE directly.
//  rst pulse while in REDIRECT: outputs drop to reset values immediately, counters 0.
//   Next mispredict after rst deasserts recovers normally.
//  Counter wrap with CNT_WIDTH=4: 16 accepts -> br_count returns to 0.

Source files
------------

// File: rtl/branch_recovery_ctrl.sv
// branch_recovery_ctrl
//   Consumes committed control-flow ops from the control buffer at the ROB head.
//   Every accepted op produces a one-cycle predictor update and bumps the branch
//   counter. A mispredicted op starts recovery: a one-cycle flush, then a redirect
//   handshake with fetch, then a fixed backend stall while the RAT and free list
//   restore from committed state.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cb_valid / cb_ready          commit handshake (ready only while idle)
//   cb_pc, cb_taken, cb_target   resolved op: PC, direction, taken target
//   cb_mispred                   prediction differed from resolution
//   flush                        one-cycle global flush
//   redirect_valid/_ready/_pc    redirect handshake towards fetch
//   backend_stall                blocks dispatch for the whole recovery
//   bp_upd_valid/_pc/_taken/_target  predictor update strobe and payload
//   br_count, mispred_count      wrapping performance counters
module branch_recovery_ctrl #(
  parameter int XLEN           = 32,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cb_valid,
  output logic                 cb_ready,
  input  logic [XLEN-1:0]      cb_pc,
  input  logic                 cb_taken,
  input  logic [XLEN-1:0]      cb_target,
  input  logic                 cb_mispred,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 redirect_ready,
  output logic                 backend_stall,
  output logic                 bp_upd_valid,
  output logic [XLEN-1:0]      bp_upd_pc,
  output logic                 bp_upd_taken,
  output logic [XLEN-1:0]      bp_upd_target,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  // The recovery counter holds RECOVER_CYCLES-1 at most.
  localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD =
    (RECOVER_CYCLES > 0) ? RC_W'(RECOVER_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_RECOVER
  } state_t;

  state_t         state_q, state_d;
  logic [RC_W-1:0] rc_cnt_q, rc_cnt_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic                 bp_valid_q;
  logic [XLEN-1:0]      bp_pc_q;
  logic                 bp_taken_q;
  logic [XLEN-1:0]      bp_target_q;
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] mp_cnt_q;

  logic accept;

  assign cb_ready = (state_q == S_IDLE);
  assign accept   = cb_valid && cb_ready;

  always_comb begin
    state_d       = state_q;
    rc_cnt_d      = rc_cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cb_mispred) begin
          state_d = S_FLUSH;
          // Not-taken recovery resumes at the fall-through, wrapping at 2^XLEN.
          redirect_pc_d = cb_taken ? cb_target : (cb_pc + XLEN'(4));
        end
      end
      S_FLUSH: begin
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          if (RECOVER_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_RECOVER;
            rc_cnt_d = RC_LOAD;
          end
        end
      end
      S_RECOVER: begin
        if (rc_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rc_cnt_d = rc_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rc_cnt_q      <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      rc_cnt_q      <= rc_cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Predictor update payload holds its last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_valid_q  <= 1'b0;
      bp_pc_q     <= '0;
      bp_taken_q  <= 1'b0;
      bp_target_q <= '0;
      br_cnt_q    <= '0;
      mp_cnt_q    <= '0;
    end else begin
      bp_valid_q <= accept;
      if (accept) begin
        bp_pc_q     <= cb_pc;
        bp_taken_q  <= cb_taken;
        bp_target_q <= cb_target;
        br_cnt_q    <= br_cnt_q + CNT_WIDTH'(1);
        if (cb_mispred) begin
          mp_cnt_q <= mp_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign flush          = (state_q == S_FLUSH);
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign backend_stall  = (state_q != S_IDLE);
  assign bp_upd_valid   = bp_valid_q;
  assign bp_upd_pc      = bp_pc_q;
  assign bp_upd_taken   = bp_taken_q;
  assign bp_upd_target  = bp_target_q;
  assign br_count       = br_cnt_q;
  assign mispred_count  = mp_cnt_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Bench for branch_recovery_ctrl: main instance with default parameters, plus a
// RECOVER_CYCLES=0 instance and a CNT_WIDTH=4 instance sharing the op payload.
module tb_branch_recovery_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus
  logic        cb_valid, cb_valid_b, cb_valid_c;
  logic [31:0] cb_pc, cb_target;
  logic        cb_taken, cb_mispred, redirect_ready;

  // main instance outputs
  logic        cb_ready, flush, redirect_valid, backend_stall, bp_upd_valid, bp_upd_taken;
  logic [31:0] redirect_pc, bp_upd_pc, bp_upd_target, br_count, mispred_count;
  // RECOVER_CYCLES=0 instance outputs
  logic        cb_ready_b, flush_b, redirect_valid_b, backend_stall_b, bp_upd_valid_b, bp_upd_taken_b;
  logic [31:0] redirect_pc_b, bp_upd_pc_b, bp_upd_target_b, br_count_b, mispred_count_b;
  // CNT_WIDTH=4 instance outputs
  logic        cb_ready_c, flush_c, redirect_valid_c, backend_stall_c, bp_upd_valid_c, bp_upd_taken_c;
  logic [31:0] redirect_pc_c, bp_upd_pc_c, bp_upd_target_c;
  logic [3:0]  br_count_c, mispred_count_c;

  branch_recovery_ctrl dut (
    .clk(clk), .rst(rst), .cb_valid(cb_valid), .cb_ready(cb_ready), .cb_pc(cb_pc),
    .cb_taken(cb_taken), .cb_target(cb_target), .cb_mispred(cb_mispred), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .backend_stall(backend_stall), .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
    .bp_upd_taken(bp_upd_taken), .bp_upd_target(bp_upd_target), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  branch_recovery_ctrl #(.RECOVER_CYCLES(0)) dut_rc0 (
    .clk(clk), .rst(rst), .cb_valid(cb_valid_b), .cb_ready(cb_ready_b), .cb_pc(cb_pc),
    .cb_taken(cb_taken), .cb_target(cb_target), .cb_mispred(cb_mispred), .flush(flush_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b), .redirect_ready(redirect_ready),
    .backend_stall(backend_stall_b), .bp_upd_valid(bp_upd_valid_b), .bp_upd_pc(bp_upd_pc_b),
    .bp_upd_taken(bp_upd_taken_b), .bp_upd_target(bp_upd_target_b), .br_count(br_count_b),
    .mispred_count(mispred_count_b)
  );

  branch_recovery_ctrl #(.CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst), .cb_valid(cb_valid_c), .cb_ready(cb_ready_c), .cb_pc(cb_pc),
    .cb_taken(cb_taken), .cb_target(cb_target), .cb_mispred(cb_mispred), .flush(flush_c),
    .redirect_valid(redirect_valid_c), .redirect_pc(redirect_pc_c), .redirect_ready(redirect_ready),
    .backend_stall(backend_stall_c), .bp_upd_valid(bp_upd_valid_c), .bp_upd_pc(bp_upd_pc_c),
    .bp_upd_taken(bp_upd_taken_c), .bp_upd_target(bp_upd_target_c), .br_count(br_count_c),
    .mispred_count(mispred_count_c)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_t;

  bp_t         exp_bp[$];
  logic [31:0] exp_redir[$];
  int          n_vec = 0;
  int          n_err = 0;
  bp_t         e;
  logic [31:0] er;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle (DUT idle) and record what it must produce.
  task automatic drive_commit(input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic mp);
    cb_pc = pc; cb_taken = tk; cb_target = tgt; cb_mispred = mp; cb_valid = 1'b1;
    exp_bp.push_back('{pc: pc, taken: tk, target: tgt});
    if (mp) exp_redir.push_back(tk ? tgt : pc + 32'd4);
    step();
    cb_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (cb_ready !== 1'b1) begin n_err++; $display("FAIL reset_cb_ready: got %b want 1", cb_ready); end
    n_vec++; if ({flush, redirect_valid, backend_stall, bp_upd_valid} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {flush, redirect_valid, backend_stall, bp_upd_valid}); end
    n_vec++; if ({redirect_pc, br_count, mispred_count} !== 96'd0) begin
      n_err++; $display("FAIL reset_regs: got %h %h %h want 0", redirect_pc, br_count, mispred_count); end
  endtask

  task automatic test_correct_nt();
    drive_commit(32'h1000, 1'b0, 32'hDEAD, 1'b0);
    n_vec++;
    if (!bp_upd_valid || exp_bp.size() == 0) begin
      n_err++; $display("FAIL nt_bp_valid: got %b want 1", bp_upd_valid);
    end else begin
      e = exp_bp.pop_front();
      if ({bp_upd_pc, bp_upd_taken, bp_upd_target} !== e) begin
        n_err++; $display("FAIL nt_bp_payload: got %h/%b/%h want %h/%b/%h",
          bp_upd_pc, bp_upd_taken, bp_upd_target, e.pc, e.taken, e.target); end
    end
    n_vec++; if ({flush, cb_ready} !== 2'b01) begin n_err++; $display("FAIL nt_flush_ready: got %b want 01", {flush, cb_ready}); end
    n_vec++; if (br_count !== 32'd1 || mispred_count !== 32'd0) begin
      n_err++; $display("FAIL nt_counts: got %0d/%0d want 1/0", br_count, mispred_count); end
    step();
    n_vec++; if (bp_upd_valid !== 1'b0) begin n_err++; $display("FAIL nt_bp_pulse: got %b want 0", bp_upd_valid); end
  endtask

  task automatic test_mispred_taken();
    redirect_ready = 1'b1;
    drive_commit(32'h3000, 1'b1, 32'h2000, 1'b1);
    // T+1
    n_vec++; if ({flush, backend_stall, cb_ready} !== 3'b110) begin
      n_err++; $display("FAIL mt_t1: flush/stall/ready got %b want 110", {flush, backend_stall, cb_ready}); end
    n_vec++;
    if (!bp_upd_valid || exp_bp.size() == 0) begin
      n_err++; $display("FAIL mt_bp_valid: got %b want 1", bp_upd_valid);
    end else begin
      e = exp_bp.pop_front();
      if ({bp_upd_pc, bp_upd_taken, bp_upd_target} !== e) begin
        n_err++; $display("FAIL mt_bp_payload: got %h want %h", {bp_upd_pc, bp_upd_taken, bp_upd_target}, e); end
    end
    step(); // T+2
    n_vec++; if ({flush, redirect_valid, backend_stall} !== 3'b011) begin
      n_err++; $display("FAIL mt_t2: flush/rv/stall got %b want 011", {flush, redirect_valid, backend_stall}); end
    n_vec++;
    if (exp_redir.size() == 0) begin n_err++; $display("FAIL mt_redir_q: got empty want entry"); end
    else begin er = exp_redir.pop_front();
      if (redirect_pc !== er) begin n_err++; $display("FAIL mt_redirect_pc: got %h want %h", redirect_pc, er); end end
    step(); // T+3
    n_vec++; if ({redirect_valid, backend_stall, cb_ready} !== 3'b010) begin
      n_err++; $display("FAIL mt_t3: rv/stall/ready got %b want 010", {redirect_valid, backend_stall, cb_ready}); end
    step(); // T+4
    n_vec++; if ({backend_stall, cb_ready} !== 2'b10) begin
      n_err++; $display("FAIL mt_t4: stall/ready got %b want 10", {backend_stall, cb_ready}); end
    step(); // T+5
    n_vec++; if ({backend_stall, cb_ready} !== 2'b01) begin
      n_err++; $display("FAIL mt_t5: stall/ready got %b want 01", {backend_stall, cb_ready}); end
    n_vec++; if (br_count !== 32'd2 || mispred_count !== 32'd1) begin
      n_err++; $display("FAIL mt_counts: got %0d/%0d want 2/1", br_count, mispred_count); end
  endtask

  task automatic test_wrap_hold();
    redirect_ready = 1'b0;
    drive_commit(32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b1);
    n_vec++;
    if (!bp_upd_valid || exp_bp.size() == 0) begin
      n_err++; $display("FAIL wh_bp_valid: got %b want 1", bp_upd_valid);
    end else begin
      e = exp_bp.pop_front();
      if ({bp_upd_pc, bp_upd_taken, bp_upd_target} !== e) begin
        n_err++; $display("FAIL wh_bp_payload: got %h want %h", {bp_upd_pc, bp_upd_taken, bp_upd_target}, e); end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (exp_redir.size() == 0 || {redirect_valid, backend_stall} !== 2'b11 || redirect_pc !== exp_redir[0]) begin
        n_err++; $display("FAIL wh_hold%0d: rv/stall %b pc %h want 11 pc 00000000", i, {redirect_valid, backend_stall}, redirect_pc); end
    end
    redirect_ready = 1'b1;
    n_vec++;
    if (exp_redir.size() == 0) begin n_err++; $display("FAIL wh_redir_q: got empty want entry"); end
    else begin er = exp_redir.pop_front();
      if (redirect_pc !== er) begin n_err++; $display("FAIL wh_redirect_pc: got %h want %h", redirect_pc, er); end end
    step(); step();
    n_vec++; if (backend_stall !== 1'b1) begin n_err++; $display("FAIL wh_recover_stall: got %b want 1", backend_stall); end
    step();
    n_vec++; if ({backend_stall, cb_ready} !== 2'b01) begin
      n_err++; $display("FAIL wh_idle: stall/ready got %b want 01", {backend_stall, cb_ready}); end
  endtask

  task automatic test_back_to_back();
    redirect_ready = 1'b1;
    drive_commit(32'h4000, 1'b1, 32'h5000, 1'b1);
    if (exp_bp.size() != 0) void'(exp_bp.pop_front());
    // second op held by upstream from T+1
    cb_pc = 32'h6000; cb_taken = 1'b0; cb_target = 32'h6100; cb_mispred = 1'b0; cb_valid = 1'b1;
    exp_bp.push_back('{pc: 32'h6000, taken: 1'b0, target: 32'h6100});
    step(); // T+2
    n_vec++;
    if (exp_redir.size() == 0) begin n_err++; $display("FAIL bb_redir_q: got empty want entry"); end
    else begin er = exp_redir.pop_front();
      if (redirect_pc !== er) begin n_err++; $display("FAIL bb_redirect_pc: got %h want %h", redirect_pc, er); end end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({cb_ready, bp_upd_valid} !== 2'b00) begin
        n_err++; $display("FAIL bb_blocked%0d: ready/bp got %b want 00", i, {cb_ready, bp_upd_valid}); end
      step();
    end
    // T+5: idle again, held op accepted at the end of this cycle
    n_vec++; if (cb_ready !== 1'b1) begin n_err++; $display("FAIL bb_ready_back: got %b want 1", cb_ready); end
    step();
    cb_valid = 1'b0;
    n_vec++;
    if (!bp_upd_valid || exp_bp.size() == 0) begin
      n_err++; $display("FAIL bb_bp_valid: got %b want 1", bp_upd_valid);
    end else begin
      e = exp_bp.pop_front();
      if ({bp_upd_pc, bp_upd_taken, bp_upd_target} !== e) begin
        n_err++; $display("FAIL bb_bp_payload: got %h want %h", {bp_upd_pc, bp_upd_taken, bp_upd_target}, e); end
    end
    n_vec++; if (br_count !== 32'd5 || mispred_count !== 32'd3) begin
      n_err++; $display("FAIL bb_counts: got %0d/%0d want 5/3", br_count, mispred_count); end
    step();
  endtask

  task automatic test_recover0();
    redirect_ready = 1'b1;
    cb_pc = 32'h9000; cb_taken = 1'b1; cb_target = 32'hA000; cb_mispred = 1'b1; cb_valid_b = 1'b1;
    step(); // T+1
    cb_valid_b = 1'b0;
    n_vec++; if ({flush_b, backend_stall_b} !== 2'b11) begin
      n_err++; $display("FAIL rc0_t1: flush/stall got %b want 11", {flush_b, backend_stall_b}); end
    step(); // T+2
    n_vec++; if (redirect_valid_b !== 1'b1 || redirect_pc_b !== 32'hA000) begin
      n_err++; $display("FAIL rc0_redirect: rv %b pc %h want 1 a000", redirect_valid_b, redirect_pc_b); end
    step(); // T+3
    n_vec++; if ({redirect_valid_b, backend_stall_b, cb_ready_b} !== 3'b001) begin
      n_err++; $display("FAIL rc0_idle: rv/stall/ready got %b want 001", {redirect_valid_b, backend_stall_b, cb_ready_b}); end
    n_vec++; if (br_count_b !== 32'd1 || mispred_count_b !== 32'd1) begin
      n_err++; $display("FAIL rc0_counts: got %0d/%0d want 1/1", br_count_b, mispred_count_b); end
  endtask

  task automatic test_rst_redirect();
    redirect_ready = 1'b0;
    drive_commit(32'h7000, 1'b1, 32'h7100, 1'b1);
    if (exp_bp.size() != 0) void'(exp_bp.pop_front());
    step(); // REDIRECT
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL rr_pre: rv got %b want 1", redirect_valid); end
    rst = 1'b1;
    #1;
    exp_redir.delete();
    n_vec++; if ({flush, redirect_valid, backend_stall, cb_ready} !== 4'b0001) begin
      n_err++; $display("FAIL rr_async: flush/rv/stall/ready got %b want 0001", {flush, redirect_valid, backend_stall, cb_ready}); end
    n_vec++; if ({redirect_pc, br_count, mispred_count} !== 96'd0) begin
      n_err++; $display("FAIL rr_regs: got %h %h %h want 0", redirect_pc, br_count, mispred_count); end
    rst = 1'b0;
    step();
    n_vec++; if ({redirect_valid, backend_stall, cb_ready} !== 3'b001) begin
      n_err++; $display("FAIL rr_post: rv/stall/ready got %b want 001", {redirect_valid, backend_stall, cb_ready}); end
    redirect_ready = 1'b1;
    drive_commit(32'h8000, 1'b0, 32'h0, 1'b1);
    if (exp_bp.size() != 0) void'(exp_bp.pop_front());
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL rr_flush: got %b want 1", flush); end
    step();
    n_vec++;
    if (exp_redir.size() == 0) begin n_err++; $display("FAIL rr_redir_q: got empty want entry"); end
    else begin er = exp_redir.pop_front();
      if (redirect_valid !== 1'b1 || redirect_pc !== er) begin
        n_err++; $display("FAIL rr_redirect: rv %b pc %h want 1 %h", redirect_valid, redirect_pc, er); end end
    step(); step(); step();
    n_vec++; if ({backend_stall, cb_ready} !== 2'b01 || br_count !== 32'd1 || mispred_count !== 32'd1) begin
      n_err++; $display("FAIL rr_recovered: stall/ready %b counts %0d/%0d want 01 1/1", {backend_stall, cb_ready}, br_count, mispred_count); end
  endtask

  task automatic test_cnt_wrap();
    cb_pc = 32'hB000; cb_taken = 1'b0; cb_target = 32'h0; cb_mispred = 1'b0; cb_valid_c = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_vec++; if (br_count_c !== 4'd15) begin n_err++; $display("FAIL cw_15: got %0d want 15", br_count_c); end
    step();
    cb_valid_c = 1'b0;
    n_vec++; if (br_count_c !== 4'd0 || mispred_count_c !== 4'd0) begin
      n_err++; $display("FAIL cw_wrap: got %0d/%0d want 0/0", br_count_c, mispred_count_c); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    cb_valid = 1'b0; cb_valid_b = 1'b0; cb_valid_c = 1'b0;
    cb_pc = '0; cb_target = '0; cb_taken = 1'b0; cb_mispred = 1'b0; redirect_ready = 1'b0;
    step(); step();
    test_reset();
    rst = 1'b0;
    step();
    test_correct_nt();
    test_mispred_taken();
    test_wrap_hold();
    test_back_to_back();
    test_recover0();
    test_rst_redirect();
    test_cnt_wrap();
    n_vec++; if (exp_bp.size() != 0 || exp_redir.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp_bp.size(), exp_redir.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
